// File: rtl/line_buff_ctrl.sv
// line_buff_ctrl
// Ping-pong sequencer for the line buffer pair. One buffer is displayed for
// TILE_HEIGHT pixel lines while the other is filled with the next tile row.
// Also flags underruns (other buffer not ready at swap) and frame-sync errors.
//
// Ports:
//   clk_i              pixel clock
//   rstn_i             asynchronous active-low reset
//   frame_start_i      frame start pulse (vertical blank)
//   line_end_i         pulse after the last active pixel of a visible line
//   active_i           high during active pixels
//   buff_fill_done_i   per-buffer fill-complete pulse
//   buff_fill_req_o    per-buffer fill request, single-cycle pulse
//   buff_sel_o         one-hot display buffer select, 00 when not displaying
//   disp_pxl_id_o      tile index of the current pixel
//   underrun_o         sticky underrun flag
//   sync_err_o         sticky frame_start-outside-IDLE flag
//   underrun_cnt_o     saturating underrun event count (LINE_BUFF_CTRL_STATS_EN only)
//
// Build option: define LINE_BUFF_CTRL_STATS_EN to add underrun_cnt_o.
//
// state   | meaning
// RESET   | first cycle after reset
// IDLE    | waiting for frame_start_i
// PREFILL | buffer 0 being filled before the first active line
// DISPLAY | showing one buffer, filling the other
module line_buff_ctrl #(
  parameter int TILE_WIDTH  = 4,
  parameter int TILE_HEIGHT = 4,
  parameter int WIDTH_PX    = 640,
  parameter int HEIGHT_PX   = 480,
  parameter int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_ROWS        = HEIGHT_PX / TILE_HEIGHT,
  parameter int LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        frame_start_i,
  input  logic                        line_end_i,
  input  logic                        active_i,
  input  logic [1:0]                  buff_fill_done_i,
  output logic [1:0]                  buff_fill_req_o,
  output logic [1:0]                  buff_sel_o,
  output logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_o,
  output logic                        underrun_o,
`ifdef LINE_BUFF_CTRL_STATS_EN
  output logic [15:0]                 underrun_cnt_o,
`endif
  output logic                        sync_err_o
);

  localparam int SUB_W  = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
  localparam int LINE_W = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int ROW_W  = (TILE_ROWS   > 1) ? $clog2(TILE_ROWS)   : 1;

  localparam logic [SUB_W-1:0]            SUB_LAST  = SUB_W'(TILE_WIDTH - 1);
  localparam logic [LINE_W-1:0]           LINE_LAST = LINE_W'(TILE_HEIGHT - 1);
  localparam logic [ROW_W-1:0]            ROW_LAST  = ROW_W'(TILE_ROWS - 1);
  localparam logic [LBUFF_ADDR_WIDTH-1:0] TILE_LAST = LBUFF_ADDR_WIDTH'(TILE_PER_LINE - 1);

  typedef enum logic [1:0] {RESET, IDLE, PREFILL, DISPLAY} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  ready_q, ready_d, ready_next;
  logic                        disp_idx_q, disp_idx_d;
  logic                        pending_q, pending_d;
  logic [SUB_W-1:0]            sub_q, sub_d;
  logic [LBUFF_ADDR_WIDTH-1:0] tile_q, tile_d;
  logic [LINE_W-1:0]           line_q, line_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [1:0]                  req_q, req_d;
  logic [1:0]                  sel_q, sel_d;
  logic                        underrun_q, underrun_d;
  logic                        sync_err_q, sync_err_d;
`ifdef LINE_BUFF_CTRL_STATS_EN
  logic [15:0]                 ur_cnt_q, ur_cnt_d;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RESET;
      ready_q    <= 2'b00;
      disp_idx_q <= 1'b0;
      pending_q  <= 1'b0;
      sub_q      <= '0;
      tile_q     <= '0;
      line_q     <= '0;
      row_q      <= '0;
      req_q      <= 2'b00;
      sel_q      <= 2'b00;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef LINE_BUFF_CTRL_STATS_EN
      ur_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      disp_idx_q <= disp_idx_d;
      pending_q  <= pending_d;
      sub_q      <= sub_d;
      tile_q     <= tile_d;
      line_q     <= line_d;
      row_q      <= row_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
`ifdef LINE_BUFF_CTRL_STATS_EN
      ur_cnt_q   <= ur_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    disp_idx_d = disp_idx_q;
    pending_d  = pending_q;
    sub_d      = sub_q;
    tile_d     = tile_q;
    line_d     = line_q;
    row_d      = row_q;
    req_d      = 2'b00;
    sel_d      = 2'b00;
    underrun_d = underrun_q;
    sync_err_d = sync_err_q;
`ifdef LINE_BUFF_CTRL_STATS_EN
    ur_cnt_d   = ur_cnt_q;
`endif
    // A done pulse landing in the swap cycle must count toward that swap.
    ready_next = ready_q | buff_fill_done_i;

    case (state_q)
      RESET: state_d = IDLE;

      IDLE: begin
        if (frame_start_i) begin
          underrun_d = 1'b0;
          sync_err_d = 1'b0;
          ready_d    = 2'b00;
          disp_idx_d = 1'b0;
          pending_d  = 1'b0;
          sub_d      = '0;
          tile_d     = '0;
          line_d     = '0;
          row_d      = '0;
          req_d      = 2'b01;
          state_d    = PREFILL;
`ifdef LINE_BUFF_CTRL_STATS_EN
          ur_cnt_d   = 16'd0;
`endif
        end
      end

      PREFILL: begin
        ready_d = ready_next;
        if (frame_start_i) sync_err_d = 1'b1;
        if (buff_fill_done_i[0]) begin
          disp_idx_d = 1'b0;
          req_d      = 2'b10;
          sel_d      = 2'b01;
          state_d    = DISPLAY;
        end
      end

      DISPLAY: begin
        ready_d = ready_next;
        sel_d   = disp_idx_q ? 2'b10 : 2'b01;
        if (frame_start_i) sync_err_d = 1'b1;

        if (line_end_i) begin
          sub_d  = '0;
          tile_d = '0;
        end else if (active_i) begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (tile_q != TILE_LAST) tile_d = tile_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end

        if (line_end_i) begin
          line_d = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
          if (line_q == LINE_LAST && row_q == ROW_LAST) begin
            state_d   = IDLE;
            sel_d     = 2'b00;
            ready_d   = 2'b00;
            pending_d = 1'b0;
          end else begin
            if (line_q == LINE_LAST) row_d = row_q + 1'b1;
            // A failed swap keeps being retried on every later line end.
            if (line_q == LINE_LAST || pending_q) begin
              if (ready_next[~disp_idx_q]) begin
                disp_idx_d          = ~disp_idx_q;
                ready_d[disp_idx_q] = 1'b0;
                pending_d           = 1'b0;
                sel_d               = disp_idx_q ? 2'b01 : 2'b10;
                if (row_d < ROW_LAST) req_d[disp_idx_q] = 1'b1;
              end else begin
                underrun_d = 1'b1;
                pending_d  = 1'b1;
`ifdef LINE_BUFF_CTRL_STATS_EN
                if (ur_cnt_q != 16'hFFFF) ur_cnt_d = ur_cnt_q + 16'd1;
`endif
              end
            end
          end
        end
      end

      default: state_d = RESET;
    endcase
  end

  assign buff_fill_req_o = req_q;
  assign buff_sel_o      = sel_q;
  assign disp_pxl_id_o   = tile_q;
  assign underrun_o      = underrun_q;
  assign sync_err_o      = sync_err_q;
`ifdef LINE_BUFF_CTRL_STATS_EN
  assign underrun_cnt_o  = ur_cnt_q;
`endif

endmodule

// File: doc/line_buff_ctrl.md
Name: line_buff_ctrl

Overview:
Sequencing controller directly upstream of the line buffer pair. It drives the pair's fill-request, buffer-select and display-pixel-index inputs, and consumes its fill-done outputs. It ping-pongs the two line buffers so that one is displayed (reused for TILE_HEIGHT pixel lines) while the other is filled with the next tile row from the frame buffer. It also flags underruns and frame-sync errors.

Parameters:
TILE_WIDTH, 4, pixels per tile horizontally
TILE_HEIGHT, 4, pixel lines per tile row (display buffer reuse count)
WIDTH_PX, 640, active pixels per line
HEIGHT_PX, 480, active lines per frame
TILE_PER_LINE, WIDTH_PX/TILE_WIDTH, tiles per line buffer (160)
TILE_ROWS, HEIGHT_PX/TILE_HEIGHT, tile rows per frame (120)
LBUFF_ADDR_WIDTH, $clog2(TILE_PER_LINE), display index width

Ports:
clk_i  in  1  pixel clock
rstn_i  in  1  asynchronous active-low reset
frame_start_i  in  1  1-cycle pulse in vertical blank, at least one full buffer-fill time before first active line
line_end_i  in  1  1-cycle pulse after the last active pixel of each visible line
active_i  in  1  high during active pixels of a visible line
buff_fill_done_i  in  2  per-buffer fill-complete pulse from line buffers
buff_fill_req_o  out  2  per-buffer fill request, 1-cycle pulse
buff_sel_o  out  2  one-hot display-buffer select; 00 when not displaying
disp_pxl_id_o  out  LBUFF_ADDR_WIDTH  tile index of current pixel
underrun_o  out  1  sticky: swap attempted while other buffer not ready
sync_err_o  out  1  sticky: frame_start_i received outside IDLE

Behaviour:
- Reset: all outputs 0, state RESET, ready[1:0]=00, disp_idx=0, counters 0.
- States: RESET -> IDLE (unconditionally, next cycle).
- IDLE: on frame_start_i, clear underrun_o and sync_err_o, zero all counters, pulse buff_fill_req_o=01 for one cycle, and move to PREFILL.
- PREFILL: on buff_fill_done_i[0]: set ready[0], disp_idx=0, pulse buff_fill_req_o=10, and move to DISPLAY.
- DISPLAY: buff_sel_o=onehot(disp_idx), registered. The bit of a buffer being filled is never set.
- Fill requests are single-cycle pulses only. Level requests are forbidden, because the line buffers re-latch a held request. At most one fill is outstanding at any time.
- ready tracking: buff_fill_done_i[n] sets ready[n]. When a buffer is retired at swap, its ready bit is cleared. If a done pulse and a swap occur in the same cycle, the swap evaluates ready_next = ready | done.
- Pixel index: sub-pixel counter 0..TILE_WIDTH-1 increments while active_i=1. On wrap, the tile counter increments, saturating at TILE_PER_LINE-1. disp_pxl_id_o = tile counter (registered). line_end_i zeroes both counters. The line buffer read latency of one cycle is absorbed downstream.
- Line counting: line_in_row counts 0..TILE_HEIGHT-1 on line_end_i. On wrap, tile_row increments and a swap occurs.
- Swap when tile_row < TILE_ROWS-1 and ready_next[~disp_idx]=1:
  - disp_idx flips and ready[old] is cleared.
  - If the new tile_row < TILE_ROWS-1, pulse buff_fill_req_o[old] in the same cycle. Otherwise no request is issued (last row).
- Swap with ready_next[~disp_idx]=0: set underrun_o. Keep displaying the current buffer. Retry the swap on every subsequent line_end_i until the other buffer is ready, with tile_row still advancing.
- Frame end: line_end_i on the last line of tile_row TILE_ROWS-1 moves to IDLE with buff_sel_o=00 and ready=00.
- frame_start_i in PREFILL or DISPLAY: ignored apart from setting sync_err_o. No fill is aborted, because the frame buffer address must stay aligned.
- Asynchronous reset mid-fill: the controller returns to RESET. The line buffers must be reset by the same rstn_i.

Optional Feature:
- Macro: LINE_BUFF_CTRL_STATS_EN.
- When defined: adds output underrun_cnt_o [15:0], a saturating count of underrun events. It is cleared at frame_start_i in IDLE and reset to 0.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then frame_start_i; done[0] after 200 cycles -> req=01 pulse, PREFILL, then req=10 pulse on done[0]; sel=01.
- Active line of 640 cycles -> disp_pxl_id_o steps 0..159, each value held 4 cycles; line_end_i returns it to 0.
- 4 line_end_i with done[1] already seen -> sel 01->10, req=01 pulse in the same cycle, ready[0] cleared.
- Withhold done[1] past the 4th line_end_i -> underrun_o=1, sel stays 01. Assert done[1] coincident with the 8th line_end_i -> swap occurs (ready_next path), no extra request collision.
- Full frame with 480 line_end_i and prompt fills -> exactly 120 fill requests total, none after row 119, sel=00 and state IDLE after the last line.
- frame_start_i mid-DISPLAY -> sync_err_o=1, sel/req unaffected. Next frame_start_i in IDLE clears it.
